// File: rtl/aes_decipher.sv
// AES-128 iterative decipher: on-chip forward key expansion (skippable when the
// stored round keys are reused), then one inverse round per clock.
module aes_decipher #(
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] Cipher_Text,
  input  logic [LENGTH-1:0] Key,
  input  logic              key_reuse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] Plain_Text,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    ROUND  = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Byte b of each table is stored at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    inv_sbox = INV_SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    for (int c = 0; c < 4; c++) begin
      inv_mix_columns[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
  endfunction

  // Row r rotates right by r columns; byte index is row + 4*column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        inv_shift_rows[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    for (int i = 0; i < 16; i++) begin
      inv_sub_bytes[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = w3 ^ n2;
    key_step = {n0, n1, n2, n3};
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  ct_q, ct_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  pt_q, pt_d;
  logic          out_valid_q, out_valid_d;
  logic          keys_valid_q, keys_valid_d;
  logic [127:0]  rk_q [11];
  logic [127:0]  rk_d [11];
  logic [127:0]  rk_prev_s, rk_round_s, exp_key_s, inv_sr_sb_s;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign Plain_Text = pt_q;

  // Round-key selection by counter and the shared datapath results.
  always_comb begin
    rk_prev_s  = rk_q[0];
    rk_round_s = rk_q[0];
    for (int i = 1; i < 11; i++) begin
      if (cnt_q == 4'(i)) begin
        rk_prev_s  = rk_q[i-1];
        rk_round_s = rk_q[i];
      end else begin
        rk_prev_s  = rk_prev_s;
        rk_round_s = rk_round_s;
      end
    end
    exp_key_s   = key_step(rk_prev_s, rcon(cnt_q));
    inv_sr_sb_s = inv_sub_bytes(inv_shift_rows(st_q));
  end

  // Next-state and datapath updates for the control FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ct_d         = ct_q;
    st_d         = st_q;
    pt_d         = pt_q;
    out_valid_d  = out_valid_q;
    keys_valid_d = keys_valid_q;
    rk_d         = rk_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (key_reuse && keys_valid_q) begin
            st_d    = Cipher_Text ^ rk_q[10];
            cnt_d   = 4'd9;
            state_d = ROUND;
          end else begin
            ct_d     = Cipher_Text;
            rk_d[0]  = Key;
            cnt_d    = 4'd1;
            state_d  = KEYEXP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      KEYEXP: begin
        for (int i = 1; i < 11; i++) begin
          if (cnt_q == 4'(i)) begin
            rk_d[i] = exp_key_s;
          end else begin
            rk_d[i] = rk_q[i];
          end
        end
        if (cnt_q == 4'd10) begin
          st_d         = ct_q ^ exp_key_s;
          keys_valid_d = 1'b1;
          cnt_d        = 4'd9;
          state_d      = ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        st_d  = inv_mix_columns(inv_sr_sb_s ^ rk_round_s);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = FINAL;
        end else begin
          state_d = ROUND;
        end
      end
      FINAL: begin
        pt_d        = inv_sr_sb_s ^ rk_q[0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      ct_q         <= 128'd0;
      st_q         <= 128'd0;
      pt_q         <= 128'd0;
      out_valid_q  <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        rk_q[i] <= 128'd0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ct_q         <= ct_d;
      st_q         <= st_d;
      pt_q         <= pt_d;
      out_valid_q  <= out_valid_d;
      keys_valid_q <= keys_valid_d;
      rk_q         <= rk_d;
    end
  end

endmodule
